// File: rtl/harvos_pkg.sv
// Shared types and constants for the harvos instruction-memory subsystem.
package harvos_pkg;

    // Bus arbiter states: idle, drive the one-cycle memory request,
    // wait for the response, and hold the bus for the last owner.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } imem_arb_state_e;

    localparam int IMEM_ARB_PORTS   = 2;
    localparam int IMEM_PORT_ICACHE = 0;
    localparam int IMEM_PORT_DBG    = 1;

endpackage

// File: rtl/imem_arb_port_buf.sv
// Per-port request buffer: remembers one pending request pulse and its
// address until the arbiter completes it, and flags a re-request that
// arrives while one is still pending.
module imem_arb_port_buf
    import harvos_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        clr,
    output logic        pend,
    output logic [31:0] paddr,
    output logic        proto_err
);

    // A pulse on a port that is still pending is dropped and reported.
    assign proto_err = req & pend;

    // Pending flag and captured address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= 1'b0;
            paddr <= '0;
        end else begin
            // NOTE: non-blocking assignments here, and the later one wins,
            // so a fresh capture would override a completion clear.
            if (clr) begin
                pend <= 1'b0;
            end
            if (req && !pend) begin
                pend  <= 1'b1;
                paddr <= addr;
            end
        end
    end

endmodule

// File: rtl/imem_bus_arbiter.sv
// Shares the external instruction-memory bus between the icache refill
// port and the debug/boot-loader port. One access outstanding at a time,
// a burst lock keeps refill beats together, and a response timeout turns
// a hung memory into a fault.
module imem_bus_arbiter
    import harvos_pkg::*;
#(
    parameter int LOCK_BEATS     = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  p_req,
    input  logic [31:0] p_addr0,
    input  logic [31:0] p_addr1,
    output logic [1:0]  p_rvalid,
    output logic [31:0] p_rdata0,
    output logic [31:0] p_rdata1,
    output logic [1:0]  p_fault,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_fault,
    output logic        err_proto,
    output logic        err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int BW = $clog2(LOCK_BEATS + 1);

    imem_arb_state_e st_q, st_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            err_proto_q, err_timeout_q;

    logic [31:0] req_addr [IMEM_ARB_PORTS];
    logic [31:0] paddr    [IMEM_ARB_PORTS];
    logic [IMEM_ARB_PORTS-1:0] pend, clr, proto_err;

    logic grant, sel, set_timeout;
    logic resp_valid, resp_fault;

    assign req_addr[IMEM_PORT_ICACHE] = p_addr0;
    assign req_addr[IMEM_PORT_DBG]    = p_addr1;

    for (genvar i = 0; i < IMEM_ARB_PORTS; i++) begin : g_port
        imem_arb_port_buf u_buf (
            .clk       (clk),
            .rst       (rst),
            .req       (p_req[i]),
            .addr      (req_addr[i]),
            .clr       (clr[i]),
            .pend      (pend[i]),
            .paddr     (paddr[i]),
            .proto_err (proto_err[i])
        );
    end

    // Next-state, grant selection, response routing and bus outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case statement can infer a latch.
        st_d        = st_q;
        owner_d     = owner_q;
        last_d      = last_q;
        beat_d      = beat_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        clr         = '0;
        set_timeout = 1'b0;
        grant       = 1'b0;
        sel         = last_q;
        resp_valid  = 1'b0;
        resp_fault  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        p_rvalid    = '0;
        p_rdata0    = '0;
        p_rdata1    = '0;
        p_fault     = '0;

        case (st_q)
            IDLE: begin
                if (|pend) begin
                    grant = 1'b1;
                    if (&pend) begin
                        sel = (beat_q < BW'(LOCK_BEATS)) ? last_q : ~last_q;
                    end else begin
                        sel = pend[1];
                    end
                end
            end
            ISSUE: begin
                mem_req  = 1'b1;
                mem_addr = paddr[owner_q];
                timer_d  = '0;
                st_d     = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp_valid   = 1'b1;
                    resp_fault   = mem_fault;
                    clr[owner_q] = 1'b1;
                    hold_d       = '0;
                    st_d         = (beat_q < BW'(LOCK_BEATS)) ? HOLD : IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid   = 1'b1;
                    resp_fault   = 1'b1;
                    set_timeout  = 1'b1;
                    clr[owner_q] = 1'b1;
                    st_d         = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                // Only the last owner may reclaim the bus inside the window.
                if (pend[last_q]) begin
                    grant = 1'b1;
                    sel   = last_q;
                end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    st_d = IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: st_d = IDLE;
        endcase

        if (grant) begin
            owner_d = sel;
            last_d  = sel;
            st_d    = ISSUE;
            if (sel == last_q) begin
                beat_d = (beat_q >= BW'(LOCK_BEATS)) ? BW'(LOCK_BEATS) : beat_q + BW'(1);
            end else begin
                beat_d = BW'(1);
            end
        end

        if (resp_valid) begin
            p_rvalid[owner_q] = 1'b1;
            p_fault[owner_q]  = resp_fault;
            if (!resp_fault || mem_rvalid) begin
                if (owner_q) p_rdata1 = mem_rdata;
                else         p_rdata0 = mem_rdata;
            end
            if (set_timeout) begin
                p_rdata0 = '0;
                p_rdata1 = '0;
            end
        end

        // A transaction caught by reset is abandoned: nothing leaves the block.
        if (rst) begin
            mem_req  = 1'b0;
            mem_addr = '0;
            p_rvalid = '0;
            p_rdata0 = '0;
            p_rdata1 = '0;
            p_fault  = '0;
        end
    end

    // State, lock counters, timers and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q          <= IDLE;
            owner_q       <= 1'b0;
            last_q        <= 1'b0;
            beat_q        <= '0;
            timer_q       <= '0;
            hold_q        <= '0;
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            st_q          <= st_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            beat_q        <= beat_d;
            timer_q       <= timer_d;
            hold_q        <= hold_d;
            err_proto_q   <= err_proto_q | (|proto_err);
            err_timeout_q <= err_timeout_q | set_timeout;
        end
    end

    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_imem_bus_arbiter.sv
// Self-checking bench for imem_bus_arbiter: directed scenarios with literal
// expectations, then randomized masters and memory against a reference model.
module tb_imem_bus_arbiter;

    localparam int LOCK  = 4;
    localparam int HOLDC = 2;
    localparam int TO    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  p_req = '0;
    logic [31:0] p_addr0 = '0, p_addr1 = '0;
    logic [1:0]  p_rvalid, p_fault;
    logic [31:0] p_rdata0, p_rdata1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_fault = 1'b0;
    logic        err_proto, err_timeout;

    imem_bus_arbiter #(.LOCK_BEATS(LOCK), .HOLD_CYCLES(HOLDC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .p_req(p_req), .p_addr0(p_addr0), .p_addr1(p_addr1),
        .p_rvalid(p_rvalid), .p_rdata0(p_rdata0), .p_rdata1(p_rdata1), .p_fault(p_fault),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_fault(mem_fault),
        .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bus occupancy is tracked as "issuing this cycle", "waiting for m_wait
    // cycles" and "holding for m_hold cycles" (-1 when not in that phase).
    int          m_last, m_streak, m_owner, m_wait, m_hold;
    bit          m_issue;
    bit          m_pend [2];
    logic [31:0] m_addr [2];
    bit          m_eproto, m_eto;

    logic        e_mem_req;
    logic [31:0] e_mem_addr;
    logic [1:0]  e_rv, e_flt;
    logic [31:0] e_rd [2];

    task automatic model_reset();
        m_last = 0; m_streak = 0; m_owner = 0; m_wait = -1; m_hold = -1;
        m_issue = 0; m_pend[0] = 0; m_pend[1] = 0; m_addr[0] = '0; m_addr[1] = '0;
        m_eproto = 0; m_eto = 0;
    endtask

    task automatic model_comb();
        e_mem_req = 0; e_mem_addr = '0; e_rv = '0; e_flt = '0; e_rd[0] = '0; e_rd[1] = '0;
        if (!rst) begin
            if (m_issue) begin
                e_mem_req  = 1;
                e_mem_addr = m_addr[m_owner];
            end
            if (m_wait >= 0) begin
                if (mem_rvalid) begin
                    e_rv[m_owner]  = 1;
                    e_rd[m_owner]  = mem_rdata;
                    e_flt[m_owner] = mem_fault;
                end else if (m_wait == TO - 1) begin
                    e_rv[m_owner]  = 1;
                    e_flt[m_owner] = 1;
                end
            end
        end
    endtask

    task automatic model_grant(input int s);
        if (s == m_last) m_streak = (m_streak + 1 > LOCK) ? LOCK : m_streak + 1;
        else             m_streak = 1;
        m_last  = s;
        m_owner = s;
        m_issue = 1;
    endtask

    task automatic model_seq();
        bit old_pend [2];
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        if (m_issue) begin
            m_issue = 0;
            m_wait  = 0;
        end else if (m_wait >= 0) begin
            if (e_rv != 2'b00) begin
                m_pend[m_owner] = 0;
                if (!mem_rvalid) m_eto = 1;
                if (mem_rvalid && m_streak < LOCK) m_hold = 0;
                m_wait = -1;
            end else begin
                m_wait++;
            end
        end else if (m_hold >= 0) begin
            if (m_pend[m_last]) begin
                m_hold = -1;
                model_grant(m_last);
            end else if (m_hold == HOLDC - 1) begin
                m_hold = -1;
            end else begin
                m_hold++;
            end
        end else if (m_pend[0] || m_pend[1]) begin
            if (m_pend[0] && m_pend[1]) s = (m_streak < LOCK) ? m_last : 1 - m_last;
            else                        s = m_pend[0] ? 0 : 1;
            model_grant(s);
        end
        for (int i = 0; i < 2; i++) begin
            if (p_req[i]) begin
                if (old_pend[i]) m_eproto = 1;
                else begin
                    m_pend[i] = 1;
                    m_addr[i] = (i == 1) ? p_addr1 : p_addr0;
                end
            end
        end
    endtask

    // ---------------- stimulus and per-cycle compare ----------------
    logic        s_rst = 0, s_mrv = 0, s_mfault = 0;
    logic [1:0]  s_req = '0;
    logic [31:0] s_addr0 = '0, s_addr1 = '0, s_mrdata = '0;

    task automatic tick();
        @(negedge clk);
        rst = s_rst; p_req = s_req; p_addr0 = s_addr0; p_addr1 = s_addr1;
        mem_rvalid = s_mrv; mem_rdata = s_mrdata; mem_fault = s_mfault;
        #2;
        model_comb();
        check("mem_req",     mem_req,          e_mem_req);
        check("mem_addr",    mem_addr,         e_mem_addr);
        check("p_rvalid",    p_rvalid,         e_rv);
        check("p_rdata0",    p_rdata0,         e_rd[0]);
        check("p_rdata1",    p_rdata1,         e_rd[1]);
        check("p_fault",     p_fault & e_rv,   e_flt);
        check("err_proto",   err_proto,        m_eproto);
        check("err_timeout", err_timeout,      m_eto);
        model_seq();
        s_req = '0; s_mrv = 0; s_rst = 0; s_mfault = 0;
    endtask

    task automatic do_reset();
        repeat (2) begin
            s_rst = 1;
            tick();
        end
    endtask

    task automatic wait_mem_req(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (mem_req === 1'b1) return;
        end
        check("mem_req_seen", mem_req, 1);
    endtask

    task automatic respond(input logic [31:0] data, input logic flt);
        s_mrv = 1; s_mrdata = data; s_mfault = flt;
        tick();
    endtask

    int n, cnt, mem_cd;
    bit m_busy [2];
    bit was_rst;

    initial begin
        model_reset();

        // 1: single refill, memory answers one cycle after mem_req
        do_reset();
        check("t1_err_proto_rst", err_proto, 0);
        check("t1_mem_req_rst", mem_req, 0);
        s_req = 2'b01; s_addr0 = 32'h0000_1000; tick();
        wait_mem_req(n);
        check("t1_latency", n, 2);
        check("t1_addr", mem_addr, 32'h0000_1000);
        respond(32'hDEAD_BEEF, 0);
        check("t1_rvalid", p_rvalid, 2'b01);
        check("t1_rdata0", p_rdata0, 32'hDEAD_BEEF);
        repeat (4) tick();

        // 2: simultaneous requests, port 0 first after reset
        do_reset();
        s_req = 2'b11; s_addr0 = 32'h100; s_addr1 = 32'h200; tick();
        wait_mem_req(n);
        check("t2_first_addr", mem_addr, 32'h100);
        respond(32'hAAAA_0000, 0);
        check("t2_rv0", p_rvalid, 2'b01);
        wait_mem_req(n);
        check("t2_gap", n, 4);
        check("t2_second_addr", mem_addr, 32'h200);
        respond(32'hBBBB_1111, 0);
        check("t2_rv1", p_rvalid, 2'b10);
        check("t2_rdata1", p_rdata1, 32'hBBBB_1111);

        // 3: four locked refill beats, then the debug port
        do_reset();
        s_req = 2'b11; s_addr0 = 32'h40; s_addr1 = 32'h80; tick();
        for (int b = 0; b < 4; b++) begin
            wait_mem_req(n);
            check("t3_beat_addr", mem_addr, 32'h40 + 32'(4 * b));
            respond(32'h1000 + 32'(b), 0);
            check("t3_beat_rv", p_rvalid, 2'b01);
            s_req = 2'b01; s_addr0 = 32'h44 + 32'(4 * b);
        end
        wait_mem_req(n);
        check("t3_fifth_addr", mem_addr, 32'h80);
        respond(32'h2222_2222, 0);
        check("t3_fifth_rv", p_rvalid, 2'b10);
        wait_mem_req(n);
        check("t3_refill_resume", mem_addr, 32'h50);
        respond(32'h3, 0);

        // 4: hold window expires, waiting port granted
        do_reset();
        s_req = 2'b01; s_addr0 = 32'h300; tick();
        s_req = 2'b10; s_addr1 = 32'h400; tick();
        wait_mem_req(n);
        check("t4_first_addr", mem_addr, 32'h300);
        respond(32'h4, 0);
        wait_mem_req(n);
        check("t4_hold_gap", n, 4);
        check("t4_second_addr", mem_addr, 32'h400);
        respond(32'h5, 1);
        check("t4_fault", p_fault, 2'b10);

        // 5: memory never answers
        do_reset();
        s_req = 2'b10; s_addr1 = 32'h500; tick();
        wait_mem_req(n);
        repeat (TO - 1) tick();
        check("t5_no_early_rv", p_rvalid, 2'b00);
        s_mrdata = 32'hFFFF_FFFF; tick();
        check("t5_rv", p_rvalid, 2'b10);
        check("t5_fault", p_fault, 2'b10);
        check("t5_rdata", p_rdata1, 32'h0);
        tick();
        check("t5_err_timeout", err_timeout, 1);
        s_mrdata = 32'h1234_5678; respond(32'h1234_5678, 0);
        check("t5_late_ignored", p_rvalid, 2'b00);

        // 6: protocol error, second pulse dropped
        do_reset();
        s_req = 2'b01; s_addr0 = 32'h600; tick();
        s_req = 2'b01; s_addr0 = 32'h604; tick();
        wait_mem_req(n);
        check("t6_err_proto", err_proto, 1);
        check("t6_addr", mem_addr, 32'h600);
        respond(32'h6, 0);
        cnt = 0;
        repeat (12) begin
            tick();
            if (mem_req === 1'b1) cnt++;
        end
        check("t6_single_access", cnt, 0);

        // 7: reset during WAIT, later response ignored
        do_reset();
        s_req = 2'b01; s_addr0 = 32'h700; tick();
        wait_mem_req(n);
        tick();
        s_rst = 1; tick();
        check("t7_rst_rvalid", p_rvalid, 2'b00);
        s_rst = 1; tick();
        respond(32'h7, 0);
        check("t7_late_rv", p_rvalid, 2'b00);
        check("t7_err_timeout", err_timeout, 0);
        check("t7_err_proto", err_proto, 0);
        cnt = 0;
        repeat (6) begin
            tick();
            if (mem_req === 1'b1) cnt++;
        end
        check("t7_abandoned", cnt, 0);

        // random masters and memory against the model
        mem_cd = -1; m_busy[0] = 0; m_busy[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            s_rst    = ($urandom_range(0, 399) == 0);
            s_addr0  = $urandom & ~32'h3;
            s_addr1  = $urandom & ~32'h3;
            s_mrdata = $urandom;
            s_mfault = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!m_busy[i] && $urandom_range(0, 3) == 0) begin
                    s_req[i]  = 1'b1;
                    m_busy[i] = 1;
                end
            end
            if (mem_cd == 0) begin
                s_mrv = 1; mem_cd = -1;
            end else if (mem_cd > 0) begin
                mem_cd--;
            end else if ($urandom_range(0, 149) == 0) begin
                s_mrv = 1;
            end
            was_rst = s_rst;
            tick();
            for (int i = 0; i < 2; i++) if (e_rv[i]) m_busy[i] = 0;
            if (was_rst) begin
                m_busy[0] = 0; m_busy[1] = 0;
            end
            if (e_mem_req) mem_cd = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
